// File: rtl/seq_fsm_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// next_state() is the KMP transition function, evaluated only for constant tables.
package seq_fsm_pkg;
  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;
  localparam int CNT_W_MIN   = 1;
  localparam int CNT_W_MAX   = 32;
  localparam int PW          = PAT_LEN_MAX + 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic logic bit_at(input logic [PW-1:0] vec, input int idx);
    logic [PW-1:0] t;
    t = vec >> idx;
    return t[0];
  endfunction

  // s holds the matched prefix followed by b, s bit 0 being the oldest bit
  function automatic int next_state(input logic [PW-1:0] pattern, input int len,
                                    input int st, input logic b);
    logic [PW-1:0] s;
    logic          ok;
    int            best;
    s    = '0;
    best = 0;
    for (int j = 0; j < st; j++) s = s | (PW'(bit_at(pattern, len - 1 - j)) << j);
    s = s | (PW'(b) << st);
    for (int k = 1; k <= len && k <= st + 1; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++)
        if (bit_at(pattern, len - 1 - i) != bit_at(s, st + 1 - k + i)) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction
endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter with sticky saturation flag.
module seq_match_counter import seq_fsm_pkg::*; #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);
  localparam logic [CNT_W-1:0] ALL1 = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc && count != ALL1) begin
      count <= count + CNT_W'(1);
      if (count == ALL1 - CNT_W'(1)) sat <= 1'b1;
    end
  end
endmodule

// File: rtl/seq_detect_fsm.sv
// Moore serial pattern detector: state = number of pattern bits matched,
// transitions from an elaboration-time KMP table, matches counted with saturation.
module seq_detect_fsm import seq_fsm_pkg::*; #(
  parameter int               PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             In1,
  input  logic             In_Valid,
  input  logic             Clr,
  output logic             Out1,
  output logic [CNT_W-1:0] Match_Count,
  output logic             Count_Sat
);
  localparam int           SW   = clog2(PAT_LEN + 1);
  localparam int           NT   = 2 * (PAT_LEN + 1);
  localparam logic [SW-1:0] FULL = SW'(PAT_LEN);

  if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_len
    $error("seq_detect_fsm: PAT_LEN out of range");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt
    $error("seq_detect_fsm: CNT_W out of range");
  end

  // Entry {S, bit}; without overlap the full state behaves like state 0
  logic [SW-1:0] trans [NT];
  for (genvar gs = 0; gs <= PAT_LEN; gs++) begin : g_st
    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
      localparam int FROM = (gs == PAT_LEN && !OVERLAP) ? 0 : gs;
      localparam logic [SW-1:0] NXT =
        SW'(next_state(PW'(PATTERN), PAT_LEN, FROM, 1'(gb)));
      assign trans[2*gs+gb] = NXT;
    end
  end

  logic [SW-1:0] state, state_nxt;
  logic          inc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= '0;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    inc       = 1'b0;
    if (Clr) begin
      state_nxt = '0;
    end else if (In_Valid) begin
      state_nxt = trans[{state, In1}];
      inc       = (state_nxt == FULL);
    end
  end

  assign Out1 = (state == FULL);

  seq_match_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (inc),
    .clr   (Clr),
    .count (Match_Count),
    .sat   (Count_Sat)
  );
endmodule
